// File: rtl/bids22_ctrl_sequencer.sv
// Host-side command sequencer for the bids22 auction engine.
// Buffers host commands in a small FIFO and plays them onto the engine's
// C_op/C_data/C_start bus one at a time, checking err and capturing maxBid.
//
// state      | meaning
// IDLE       | waiting for a queued command; pops the FIFO head
// ISSUE      | config op is on C_op/C_data for this single cycle
// CHECK      | bus back to NO_OP; engine err sampled for the config op
// WAIT_READY | round queued; waiting for engine ready before C_start
// ROUND      | C_start high; counter runs down the round length
// WAIT_OVER  | C_start low; waiting for roundOver to capture maxBid
module bids22_ctrl_sequencer #(
  parameter int DATAWIDTH = 32,
  parameter int OPWIDTH   = 4,
  parameter int ERRW      = 3,
  parameter int FIFODEPTH = 4
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 cmd_valid,
  output logic                 cmd_ready,
  input  logic                 cmd_round,
  input  logic [OPWIDTH-1:0]   cmd_op,
  input  logic [DATAWIDTH-1:0] cmd_data,
  output logic [OPWIDTH-1:0]   C_op,
  output logic [DATAWIDTH-1:0] C_data,
  output logic                 C_start,
  input  logic                 ready,
  input  logic [ERRW-1:0]      err,
  input  logic                 roundOver,
  input  logic [DATAWIDTH-1:0] maxBid,
  output logic                 res_valid,
  output logic [DATAWIDTH-1:0] res_maxBid,
  output logic                 seq_err,
  output logic                 busy
);

  localparam int AW = $clog2(FIFODEPTH);
  localparam int CW = AW + 1;
  localparam logic [OPWIDTH-1:0] NO_OP = '0;

  localparam logic [2:0] S_IDLE       = 3'd0;
  localparam logic [2:0] S_ISSUE      = 3'd1;
  localparam logic [2:0] S_CHECK      = 3'd2;
  localparam logic [2:0] S_WAIT_READY = 3'd3;
  localparam logic [2:0] S_ROUND      = 3'd4;
  localparam logic [2:0] S_WAIT_OVER  = 3'd5;

  // FIFO storage, one field per array
  logic                 mem_round_q [FIFODEPTH];
  logic [OPWIDTH-1:0]   mem_op_q    [FIFODEPTH];
  logic [DATAWIDTH-1:0] mem_data_q  [FIFODEPTH];

  logic [AW-1:0]        wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]        rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]        count_q, count_d;

  logic [2:0]           state_q, state_d;
  logic [DATAWIDTH-1:0] cnt_q, cnt_d;
  logic [OPWIDTH-1:0]   c_op_q, c_op_d;
  logic [DATAWIDTH-1:0] c_data_q, c_data_d;
  logic                 c_start_q, c_start_d;
  logic                 res_valid_q, res_valid_d;
  logic [DATAWIDTH-1:0] res_maxbid_q, res_maxbid_d;
  logic                 seq_err_q, seq_err_d;

  logic                 push;
  logic                 pop;
  logic                 head_round;
  logic [OPWIDTH-1:0]   head_op;
  logic [DATAWIDTH-1:0] head_data;
  logic                 err_seen;

  assign cmd_ready  = (count_q != CW'(FIFODEPTH));
  assign push       = cmd_valid && cmd_ready;
  assign pop        = (state_q == S_IDLE) && (count_q != '0);
  assign head_round = mem_round_q[rd_ptr_q];
  assign head_op    = mem_op_q[rd_ptr_q];
  assign head_data  = mem_data_q[rd_ptr_q];
  assign err_seen   = (err != '0);

  // FIFO pointer and occupancy next-state
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push) wr_ptr_d = wr_ptr_q + AW'(1);
    if (pop)  rd_ptr_d = rd_ptr_q + AW'(1);
    count_d = count_q + CW'(push) - CW'(pop);
  end

  // Sequencer next-state and registered bus outputs
  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    c_op_d       = NO_OP;
    c_data_d     = '0;
    c_start_d    = 1'b0;
    res_valid_d  = 1'b0;
    res_maxbid_d = res_maxbid_q;
    seq_err_d    = seq_err_q;
    case (state_q)
      S_IDLE: begin
        if (pop) begin
          if (!head_round) begin
            c_op_d   = head_op;
            c_data_d = head_data;
            state_d  = S_ISSUE;
          end else if (head_data == '0) begin
            // zero-length round would never end; reject it
            seq_err_d = 1'b1;
          end else begin
            cnt_d   = head_data;
            state_d = S_WAIT_READY;
          end
        end
      end
      S_ISSUE: state_d = S_CHECK;
      S_CHECK: begin
        if (err_seen) seq_err_d = 1'b1;
        state_d = S_IDLE;
      end
      S_WAIT_READY: begin
        if (err_seen) seq_err_d = 1'b1;
        if (ready) begin
          c_start_d = 1'b1;
          state_d   = S_ROUND;
        end
      end
      S_ROUND: begin
        if (err_seen) seq_err_d = 1'b1;
        cnt_d = cnt_q - DATAWIDTH'(1);
        if (cnt_q == DATAWIDTH'(1)) state_d = S_WAIT_OVER;
        else                        c_start_d = 1'b1;
      end
      S_WAIT_OVER: begin
        if (roundOver) begin
          res_valid_d  = 1'b1;
          res_maxbid_d = maxBid;
          if (err_seen) seq_err_d = 1'b1;
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // FIFO entry write on accepted push
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < FIFODEPTH; i++) begin
        mem_round_q[i] <= 1'b0;
        mem_op_q[i]    <= '0;
        mem_data_q[i]  <= '0;
      end
    end else if (push) begin
      mem_round_q[wr_ptr_q] <= cmd_round;
      mem_op_q[wr_ptr_q]    <= cmd_op;
      mem_data_q[wr_ptr_q]  <= cmd_data;
    end
  end

  // State, counter, pointers and output registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      count_q      <= '0;
      state_q      <= S_IDLE;
      cnt_q        <= '0;
      c_op_q       <= NO_OP;
      c_data_q     <= '0;
      c_start_q    <= 1'b0;
      res_valid_q  <= 1'b0;
      res_maxbid_q <= '0;
      seq_err_q    <= 1'b0;
    end else begin
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      count_q      <= count_d;
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      c_op_q       <= c_op_d;
      c_data_q     <= c_data_d;
      c_start_q    <= c_start_d;
      res_valid_q  <= res_valid_d;
      res_maxbid_q <= res_maxbid_d;
      seq_err_q    <= seq_err_d;
    end
  end

  assign C_op       = c_op_q;
  assign C_data     = c_data_q;
  assign C_start    = c_start_q;
  assign res_valid  = res_valid_q;
  assign res_maxBid = res_maxbid_q;
  assign seq_err    = seq_err_q;
  assign busy       = (state_q != S_IDLE) || (count_q != '0);

endmodule

// File: tb/tb_bids22_ctrl_sequencer.sv
// Directed-vector bench for bids22_ctrl_sequencer: a per-cycle table of
// inputs and expected outputs, plus hand sequences for back-to-back config
// issue and reset in the middle of a round.
module tb_bids22_ctrl_sequencer;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        cmd_valid = 1'b0;
  logic        cmd_ready;
  logic        cmd_round = 1'b0;
  logic [3:0]  cmd_op = '0;
  logic [31:0] cmd_data = '0;
  logic [3:0]  C_op;
  logic [31:0] C_data;
  logic        C_start;
  logic        ready = 1'b0;
  logic [2:0]  err = '0;
  logic        roundOver = 1'b0;
  logic [31:0] maxBid = '0;
  logic        res_valid;
  logic [31:0] res_maxBid;
  logic        seq_err;
  logic        busy;

  int n_vec = 0;
  int n_miss = 0;

  bids22_ctrl_sequencer #(.DATAWIDTH(32), .OPWIDTH(4), .ERRW(3), .FIFODEPTH(4)) dut (
    .clk(clk), .reset(reset),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_round(cmd_round),
    .cmd_op(cmd_op), .cmd_data(cmd_data),
    .C_op(C_op), .C_data(C_data), .C_start(C_start),
    .ready(ready), .err(err), .roundOver(roundOver), .maxBid(maxBid),
    .res_valid(res_valid), .res_maxBid(res_maxBid), .seq_err(seq_err), .busy(busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        rst, val, rnd;
    logic [3:0]  op;
    logic [31:0] data;
    logic        rdy;
    logic [2:0]  er;
    logic        rov;
    logic [31:0] mb;
    logic [3:0]  e_op;
    logic [31:0] e_data;
    logic        e_st, e_crdy, e_rv;
    logic [31:0] e_rm;
    logic        e_serr, e_busy;
  } vec_t;

  vec_t vecs[$];

  task automatic v(input logic rst_i, val_i, rnd_i, input logic [3:0] op_i,
                   input logic [31:0] data_i, input logic rdy_i, input logic [2:0] er_i,
                   input logic rov_i, input logic [31:0] mb_i,
                   input logic [3:0] e_op_i, input logic [31:0] e_data_i,
                   input logic e_st_i, e_crdy_i, e_rv_i, input logic [31:0] e_rm_i,
                   input logic e_serr_i, e_busy_i);
    vec_t t;
    t.rst = rst_i; t.val = val_i; t.rnd = rnd_i; t.op = op_i; t.data = data_i;
    t.rdy = rdy_i; t.er = er_i; t.rov = rov_i; t.mb = mb_i;
    t.e_op = e_op_i; t.e_data = e_data_i; t.e_st = e_st_i; t.e_crdy = e_crdy_i;
    t.e_rv = e_rv_i; t.e_rm = e_rm_i; t.e_serr = e_serr_i; t.e_busy = e_busy_i;
    vecs.push_back(t);
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  initial begin
    // rst val rnd op data rdy err rov mb | C_op C_data start crdy rv rm serr busy
    // reset state
    v(1,0,0,0,0,0,0,0,0,        0,0,0,1,0,0,0,0);
    // single config LOCK(2)/0xA5
    v(0,1,0,2,'hA5,0,0,0,0,     0,0,0,1,0,0,0,1);
    v(0,0,0,0,0,0,0,0,0,        2,'hA5,0,1,0,0,0,1);
    v(0,0,0,0,0,0,0,0,0,        0,0,0,1,0,0,0,1);
    v(0,0,0,0,0,0,0,0,0,        0,0,0,1,0,0,0,0);
    // round of 4 cycles, ready held low, stray roundOver during ROUND ignored
    v(0,1,1,7,4,0,0,0,0,        0,0,0,1,0,0,0,1);
    v(0,0,0,0,0,0,0,0,0,        0,0,0,1,0,0,0,1);
    v(0,0,0,0,0,0,0,0,0,        0,0,0,1,0,0,0,1);
    v(0,0,0,0,0,0,0,0,0,        0,0,0,1,0,0,0,1);
    v(0,0,0,0,0,1,0,0,0,        0,0,1,1,0,0,0,1);
    v(0,0,0,0,0,1,0,0,0,        0,0,1,1,0,0,0,1);
    v(0,0,0,0,0,1,0,1,'h99,     0,0,1,1,0,0,0,1);
    v(0,0,0,0,0,1,0,0,0,        0,0,1,1,0,0,0,1);
    v(0,0,0,0,0,1,0,0,0,        0,0,0,1,0,0,0,1);
    v(0,0,0,0,0,0,0,1,'h37,     0,0,0,1,1,'h37,0,0);
    v(0,0,0,0,0,0,0,0,0,        0,0,0,1,0,'h37,0,0);
    // zero-length round rejected
    v(0,1,1,3,0,0,0,0,0,        0,0,0,1,0,'h37,0,1);
    v(0,0,0,0,0,0,0,0,0,        0,0,0,1,0,'h37,1,0);
    v(1,0,0,0,0,0,0,0,0,        0,0,0,1,0,0,0,0);
    // config with err in CHECK, then a further config still runs
    v(0,1,0,1,'h11,0,0,0,0,     0,0,0,1,0,0,0,1);
    v(0,0,0,0,0,0,0,0,0,        1,'h11,0,1,0,0,0,1);
    v(0,0,0,0,0,0,0,0,0,        0,0,0,1,0,0,0,1);
    v(0,0,0,0,0,0,3,0,0,        0,0,0,1,0,0,1,0);
    v(0,1,0,4,'h22,0,0,0,0,     0,0,0,1,0,0,1,1);
    v(0,0,0,0,0,0,0,0,0,        4,'h22,0,1,0,0,1,1);
    v(0,0,0,0,0,0,0,0,0,        0,0,0,1,0,0,1,1);
    v(0,0,0,0,0,0,0,0,0,        0,0,0,1,0,0,1,0);
    v(1,0,0,0,0,0,0,0,0,        0,0,0,1,0,0,0,0);
    // err during WAIT_READY, one-cycle round
    v(0,1,1,0,1,0,0,0,0,        0,0,0,1,0,0,0,1);
    v(0,0,0,0,0,0,0,0,0,        0,0,0,1,0,0,0,1);
    v(0,0,0,0,0,0,5,0,0,        0,0,0,1,0,0,1,1);
    v(0,0,0,0,0,1,0,0,0,        0,0,1,1,0,0,1,1);
    v(0,0,0,0,0,1,0,0,0,        0,0,0,1,0,0,1,1);
    v(0,0,0,0,0,0,0,1,'hDEADBEEF, 0,0,0,1,1,'hDEADBEEF,1,0);
    v(1,0,0,0,0,0,0,0,0,        0,0,0,1,0,0,0,0);
    // fill FIFO while a round waits; 5th push refused; err with roundOver
    v(0,1,1,0,2,0,0,0,0,        0,0,0,1,0,0,0,1);
    v(0,1,0,1,1,0,0,0,0,        0,0,0,1,0,0,0,1);
    v(0,1,0,2,2,0,0,0,0,        0,0,0,1,0,0,0,1);
    v(0,1,0,3,3,0,0,0,0,        0,0,0,1,0,0,0,1);
    v(0,1,0,4,4,0,0,0,0,        0,0,0,0,0,0,0,1);
    v(0,1,0,5,5,0,0,0,0,        0,0,0,0,0,0,0,1);
    v(0,0,0,0,0,1,0,0,0,        0,0,1,0,0,0,0,1);
    v(0,0,0,0,0,1,0,0,0,        0,0,1,0,0,0,0,1);
    v(0,0,0,0,0,1,0,0,0,        0,0,0,0,0,0,0,1);
    v(0,0,0,0,0,0,2,1,5,        0,0,0,0,1,5,1,1);
    v(0,0,0,0,0,0,0,0,0,        1,1,0,1,0,5,1,1);
    v(0,0,0,0,0,0,0,0,0,        0,0,0,1,0,5,1,1);
    v(0,0,0,0,0,0,0,0,0,        0,0,0,1,0,5,1,1);
    v(0,0,0,0,0,0,0,0,0,        2,2,0,1,0,5,1,1);
    v(0,0,0,0,0,0,0,0,0,        0,0,0,1,0,5,1,1);
    v(0,0,0,0,0,0,0,0,0,        0,0,0,1,0,5,1,1);
    v(0,0,0,0,0,0,0,0,0,        3,3,0,1,0,5,1,1);
    v(0,0,0,0,0,0,0,0,0,        0,0,0,1,0,5,1,1);
    v(0,0,0,0,0,0,0,0,0,        0,0,0,1,0,5,1,1);
    v(0,0,0,0,0,0,0,0,0,        4,4,0,1,0,5,1,1);
    v(0,0,0,0,0,0,0,0,0,        0,0,0,1,0,5,1,1);
    v(0,0,0,0,0,0,0,0,0,        0,0,0,1,0,5,1,0);

    foreach (vecs[i]) begin
      @(negedge clk);
      reset = vecs[i].rst; cmd_valid = vecs[i].val; cmd_round = vecs[i].rnd;
      cmd_op = vecs[i].op; cmd_data = vecs[i].data; ready = vecs[i].rdy;
      err = vecs[i].er; roundOver = vecs[i].rov; maxBid = vecs[i].mb;
      @(posedge clk); #1;
      n_vec++;
      chk($sformatf("v%0d C_op", i), 32'(C_op), 32'(vecs[i].e_op));
      chk($sformatf("v%0d C_data", i), C_data, vecs[i].e_data);
      chk($sformatf("v%0d C_start", i), 32'(C_start), 32'(vecs[i].e_st));
      chk($sformatf("v%0d cmd_ready", i), 32'(cmd_ready), 32'(vecs[i].e_crdy));
      chk($sformatf("v%0d res_valid", i), 32'(res_valid), 32'(vecs[i].e_rv));
      chk($sformatf("v%0d res_maxBid", i), res_maxBid, vecs[i].e_rm);
      chk($sformatf("v%0d seq_err", i), 32'(seq_err), 32'(vecs[i].e_serr));
      chk($sformatf("v%0d busy", i), 32'(busy), 32'(vecs[i].e_busy));
    end

    // reset in the middle of a round with a config still queued
    @(negedge clk);
    reset = 1'b0; cmd_valid = 1'b1; cmd_round = 1'b1; cmd_op = '0; cmd_data = 5;
    ready = 1'b1; err = '0; roundOver = 1'b0; maxBid = '0;
    @(negedge clk);
    cmd_round = 1'b0; cmd_op = 6; cmd_data = 'h66;
    @(negedge clk);
    cmd_valid = 1'b0;
    repeat (4) @(posedge clk);
    #2;
    n_vec++;
    chk("mid-round C_start before reset", 32'(C_start), 32'(1));
    chk("mid-round busy before reset", 32'(busy), 32'(1));
    reset = 1'b1;
    #1;
    n_vec++;
    chk("async reset C_start", 32'(C_start), 32'(0));
    chk("async reset cmd_ready", 32'(cmd_ready), 32'(1));
    chk("async reset busy", 32'(busy), 32'(0));
    chk("async reset res_maxBid", res_maxBid, 32'(0));
    chk("async reset seq_err", 32'(seq_err), 32'(0));
    @(negedge clk);
    reset = 1'b0;
    for (int n = 0; n < 4; n++) begin
      @(posedge clk); #1;
      n_vec++;
      chk($sformatf("post-reset C_op c%0d", n), 32'(C_op), 32'(0));
      chk($sformatf("post-reset C_start c%0d", n), 32'(C_start), 32'(0));
      chk($sformatf("post-reset busy c%0d", n), 32'(busy), 32'(0));
    end

    // five back-to-back config pushes, issued every third cycle
    for (int n = 0; n < 18; n++) begin
      logic [3:0]  e_op;
      logic [31:0] e_data;
      int k;
      @(negedge clk);
      cmd_valid = (n < 5); cmd_round = 1'b0;
      cmd_op = 4'(n + 1); cmd_data = 32'h100 + 32'(n);
      @(posedge clk); #1;
      e_op = '0; e_data = '0;
      k = (n - 1) / 3;
      if (n >= 1 && ((n - 1) % 3) == 0 && k < 5) begin
        e_op = 4'(k + 1);
        e_data = 32'h100 + 32'(k);
      end
      n_vec++;
      chk($sformatf("b2b C_op c%0d", n), 32'(C_op), 32'(e_op));
      chk($sformatf("b2b C_data c%0d", n), C_data, e_data);
      chk($sformatf("b2b cmd_ready c%0d", n), 32'(cmd_ready), 32'(1));
    end
    cmd_valid = 1'b0;
    n_vec++;
    chk("b2b busy at end", 32'(busy), 32'(0));
    chk("b2b seq_err at end", 32'(seq_err), 32'(0));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
